// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared types and helpers for the up/down modulo counter.
//                count_dir_e encodes the direction input; terminal_value
//                derives the highest legal count from the modulus.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  // Highest count reachable for a given modulus (the count range is 0..MODULUS-1).
  // 64-bit so that MODULUS = 2**32 is representable.
  function automatic logic [63:0] terminal_value(input logic [63:0] modulus);
    return modulus - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/n_bit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : n_bit_adder
//  Description : Parametrised ripple-carry adder built from full-adder cells.
//  Ports       : a, b  - WIDTH-bit operands
//                cin   - carry in
//                sum   - WIDTH-bit sum
//                cout  - carry out of the top bit
//  Revision    : 1.0 - initial release
// ============================================================================
module n_bit_adder
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_updown_counter
//  Description : Parametrised synchronous up/down modulo counter with count
//                enable, synchronous clear, clamped parallel load, elaboration
//                -time wrap/saturate mode, combinational terminal count and a
//                registered one-cycle wrap pulse. Stages cascade by feeding
//                tc of one stage into en of the next.
//  Ports       : clk      - rising-edge clock
//                rst      - asynchronous reset, active-low
//                en       - count enable
//                up       - direction, 1 = increment, 0 = decrement
//                clr      - synchronous clear to 0 (highest priority)
//                load     - synchronous parallel load
//                load_val - value to load, clamped to MODULUS-1
//                count    - current count (registered)
//                tc       - terminal count (combinational)
//                wrap     - one-cycle pulse after a wrap-around edge
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter logic [63:0] MODULUS  = 64'd1 << WIDTH,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // --------------------------------------------------------------------------
  if ((WIDTH < 2) || (WIDTH > 32) || (MODULUS < 64'd2) ||
      (MODULUS > (64'd1 << WIDTH))) begin : g_param_check
    $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] c_TERM = WIDTH'(terminal_value(MODULUS));

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  count_dir_e       w_dir;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout_unused;
  logic             w_at_term;
  logic             w_at_zero;
  logic             w_load_over;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;

  assign w_dir = count_dir_e'(up);

  // Decrement is count + all-ones; carry-out is deliberately discarded and
  // boundaries are found by compare so non-power-of-2 moduli stay correct.
  assign w_addend = (w_dir == DIR_UP) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};

  n_bit_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (r_count),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout_unused)
  );

  assign w_at_term   = (r_count == c_TERM);
  assign w_at_zero   = (r_count == '0);
  assign w_load_over = (load_val > c_TERM);

  // --------------------------------------------------------------------------
  // Next-state: clr > load > en > hold
  // --------------------------------------------------------------------------
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    if (clr) begin
      w_count_nxt = '0;
    end else if (load) begin
      w_count_nxt = w_load_over ? c_TERM : load_val;
    end else if (en) begin
      if (w_dir == DIR_UP) begin
        if (w_at_term) begin
          if (!SATURATE) begin
            w_count_nxt = '0;
            w_wrap_nxt  = 1'b1;
          end
        end else begin
          w_count_nxt = w_sum;
        end
      end else begin
        if (w_at_zero) begin
          if (!SATURATE) begin
            w_count_nxt = c_TERM;
            w_wrap_nxt  = 1'b1;
          end
        end else begin
          w_count_nxt = w_sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. tc is combinational so a cascaded stage advances on the same edge.
  // --------------------------------------------------------------------------
  assign count = r_count;
  assign wrap  = r_wrap;
  assign tc    = en & ((w_dir == DIR_UP) ? w_at_term : w_at_zero);

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_updown_counter
//  Description : Directed self-checking bench for mod_updown_counter
//                (WIDTH=4, MODULUS=10) in wrap and saturate modes, plus a
//                two-stage decade cascade.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_updown_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // wrap-mode instance
  logic       en = 0, up = 0, clr = 0, load = 0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] count;
  logic       tc, wrap;

  // saturate-mode instance
  logic       s_en = 0, s_up = 0, s_clr = 0, s_load = 0;
  logic [3:0] s_load_val = 4'd0;
  logic [3:0] s_count;
  logic       s_tc, s_wrap;

  // cascade: low stage tc drives high stage en
  logic       l_en = 0;
  logic       one = 1'b1, zero = 1'b0;
  logic [3:0] zero4 = 4'd0;
  logic [3:0] l_count, h_count;
  logic       l_tc, l_wrap, h_tc, h_wrap;

  mod_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .wrap(wrap));

  mod_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(s_en), .up(s_up), .clr(s_clr), .load(s_load),
    .load_val(s_load_val), .count(s_count), .tc(s_tc), .wrap(s_wrap));

  mod_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) u_lo (
    .clk(clk), .rst(rst), .en(l_en), .up(one), .clr(zero), .load(zero),
    .load_val(zero4), .count(l_count), .tc(l_tc), .wrap(l_wrap));

  mod_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) u_hi (
    .clk(clk), .rst(rst), .en(l_tc), .up(one), .clr(zero), .load(zero),
    .load_val(zero4), .count(h_count), .tc(h_tc), .wrap(h_wrap));

  task automatic test_reset;
    #1 rst = 1'b0;
    @(negedge clk);
    en = 1'b1; up = 1'b0;
    #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %0b want 0", wrap); end
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL reset_tc_down: got %0b want 1", tc); end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_count_up;
    logic [3:0] e;
    @(negedge clk);
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      e = 4'(k % 10);
      total++; if (count !== e) begin bad++; $display("FAIL up_count k=%0d: got %0d want %0d", k, count, e); end
      total++; if (wrap !== (k == 10)) begin bad++; $display("FAIL up_wrap k=%0d: got %0b want %0b", k, wrap, (k == 10)); end
      total++; if (tc !== (e == 4'd9)) begin bad++; $display("FAIL up_tc k=%0d: got %0b want %0b", k, tc, (e == 4'd9)); end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic test_count_down;
    logic [3:0] e;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; en = 1'b1; up = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      e = (k == 0) ? 4'd0 : 4'(10 - k);
      total++; if (count !== e) begin bad++; $display("FAIL dn_count k=%0d: got %0d want %0d", k, count, e); end
      total++; if (wrap !== (k == 1)) begin bad++; $display("FAIL dn_wrap k=%0d: got %0b want %0b", k, wrap, (k == 1)); end
      total++; if (tc !== (k == 0)) begin bad++; $display("FAIL dn_tc k=%0d: got %0b want %0b", k, tc, (k == 0)); end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic test_saturate;
    logic [3:0] e;
    @(negedge clk);
    s_en = 1'b1; s_up = 1'b1;
    for (int k = 0; k < 13; k++) begin
      #1;
      e = (k > 9) ? 4'd9 : 4'(k);
      total++; if (s_count !== e) begin bad++; $display("FAIL sat_count k=%0d: got %0d want %0d", k, s_count, e); end
      total++; if (s_wrap !== 1'b0) begin bad++; $display("FAIL sat_wrap k=%0d: got %0b want 0", k, s_wrap); end
      total++; if (s_tc !== (e == 4'd9)) begin bad++; $display("FAIL sat_tc k=%0d: got %0b want %0b", k, s_tc, (e == 4'd9)); end
      @(negedge clk);
    end
    s_up = 1'b0;
    #1;
    total++; if (s_tc !== 1'b0) begin bad++; $display("FAIL sat_tc_dn: got %0b want 0", s_tc); end
    @(negedge clk);
    #1;
    total++; if (s_count !== 4'd8) begin bad++; $display("FAIL sat_dn_count: got %0d want 8", s_count); end
    s_en = 1'b0;
  endtask

  task automatic test_priority;
    @(negedge clk);
    en = 1'b0; up = 1'b1; load = 1'b1; load_val = 4'd5;
    @(negedge clk); #1;
    total++; if (count !== 4'd5) begin bad++; $display("FAIL pri_load5: got %0d want 5", count); end
    clr = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b1;
    @(negedge clk); #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL pri_clr: got %0d want 0", count); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL pri_clr_wrap: got %0b want 0", wrap); end
    clr = 1'b0; en = 1'b0; load_val = 4'd14;
    @(negedge clk); #1;
    total++; if (count !== 4'd9) begin bad++; $display("FAIL pri_clamp14: got %0d want 9", count); end
    load_val = 4'd10;
    @(negedge clk); #1;
    total++; if (count !== 4'd9) begin bad++; $display("FAIL pri_clamp10: got %0d want 9", count); end
    load_val = 4'd3; en = 1'b1;
    @(negedge clk); #1;
    total++; if (count !== 4'd3) begin bad++; $display("FAIL pri_load3: got %0d want 3", count); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_async_reset;
    load = 1'b1; load_val = 4'd7;
    @(negedge clk);
    load = 1'b0;
    #1;
    total++; if (count !== 4'd7) begin bad++; $display("FAIL ar_pre: got %0d want 7", count); end
    en = 1'b1; up = 1'b1; rst = 1'b0;
    #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL ar_count: got %0d want 0", count); end
    @(negedge clk);
    total++; if (count !== 4'd0) begin bad++; $display("FAIL ar_hold: got %0d want 0", count); end
    rst = 1'b1;
    @(negedge clk); #1;
    total++; if (count !== 4'd1) begin bad++; $display("FAIL ar_first: got %0d want 1", count); end
    // reset must also kill a pending wrap pulse
    en = 1'b0; load = 1'b1; load_val = 4'd9;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b1;
    @(negedge clk); #1;
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL ar_wrap_pre: got %0b want 1", wrap); end
    rst = 1'b0; en = 1'b0;
    #1;
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL ar_wrap: got %0b want 0", wrap); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_cascade;
    int early = 0;
    @(negedge clk);
    l_en = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk); #1;
      if (cyc == 25) begin
        total++; if (h_count !== 4'd2 || l_count !== 4'd5) begin
          bad++; $display("FAIL cas_25: got hi=%0d lo=%0d want hi=2 lo=5", h_count, l_count); end
      end
      if (cyc == 99) begin
        total++; if (l_tc !== 1'b1 || h_tc !== 1'b1) begin
          bad++; $display("FAIL cas_tc99: got lo_tc=%0b hi_tc=%0b want 1 1", l_tc, h_tc); end
      end
      if (cyc < 100 && h_wrap) early++;
      if (cyc == 100) begin
        total++; if (h_wrap !== 1'b1 || h_count !== 4'd0) begin
          bad++; $display("FAIL cas_wrap100: got wrap=%0b hi=%0d want wrap=1 hi=0", h_wrap, h_count); end
      end
    end
    total++; if (early !== 0) begin bad++; $display("FAIL cas_early_wrap: got %0d want 0", early); end
    l_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_priority();
    test_async_reset();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
